// File: rtl/serializador_pkg.sv
// Shared types and default constants for the byte serializer.
// The state encoding lives here so monitors can decode state_q symbolically.
package serializador_pkg;

  localparam int DATA_W_DEFAULT     = 8;
  localparam int GAP_CYCLES_DEFAULT = 1;
  localparam int MSB_FIRST_DEFAULT  = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

endpackage

// File: rtl/serializador.sv
// Pops one byte from an external queue and shifts it out serially with a bit strobe.
// Optional even-parity trailer bit is enabled with `define PARITY_EN.
module serializador
  import serializador_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int GAP_CYCLES = GAP_CYCLES_DEFAULT,
  parameter int MSB_FIRST  = MSB_FIRST_DEFAULT
) (
  input  logic              clk_10KHz,
  input  logic              reset,
  input  logic [7:0]        len_in,
  input  logic [DATA_W-1:0] q_data_in,
  input  logic              enable_in,
  input  logic              ready_in,
  output logic              dequeue_out,
  output logic              data_out,
  output logic              write_out,
  output logic              busy_out,
  output logic              done_out
);

  localparam int CNT_W = $clog2(DATA_W + 1);
`ifdef PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBITS - 1);
  localparam logic [3:0]       GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t            state_q;
  logic [DATA_W-1:0] sh_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [3:0]        gap_q;
  logic              dequeue_q;
  logic              data_q;
  logic              write_q;
  logic              busy_q;
  logic              done_q;
`ifdef PARITY_EN
  logic              par_q;
`endif

  logic              start_d;
  logic              head_bit_d;
  logic [DATA_W-1:0] sh_d;
  logic              load_bit_d;
  logic [DATA_W-1:0] load_sh_d;

  assign start_d = enable_in && ready_in && (len_in != 8'd0);

  // The register always presents the next bit to send at its head.
  always_comb begin
    head_bit_d = 1'b0;
    sh_d       = '0;
    load_bit_d = 1'b0;
    load_sh_d  = '0;
    if (MSB_FIRST != 0) begin
      head_bit_d = sh_q[DATA_W-1];
      sh_d       = sh_q << 1;
      load_bit_d = q_data_in[DATA_W-1];
      load_sh_d  = q_data_in << 1;
    end else begin
      head_bit_d = sh_q[0];
      sh_d       = sh_q >> 1;
      load_bit_d = q_data_in[0];
      load_sh_d  = q_data_in >> 1;
    end
  end

  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sh_q      <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      dequeue_q <= 1'b0;
      data_q    <= 1'b0;
      write_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      dequeue_q <= 1'b0;
      done_q    <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start_d) begin
            state_q   <= ST_REQ;
            dequeue_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        ST_REQ: begin
          state_q <= ST_LOAD;
        end
        // Queue head is valid now; first bit goes out registered next cycle.
        ST_LOAD: begin
          state_q <= ST_SHIFT;
          sh_q    <= load_sh_d;
          cnt_q   <= '0;
          write_q <= 1'b1;
          data_q  <= load_bit_d;
`ifdef PARITY_EN
          par_q   <= ^q_data_in;
`endif
        end
        ST_SHIFT: begin
          if (cnt_q == LAST_CNT) begin
            write_q <= 1'b0;
            data_q  <= 1'b0;
            done_q  <= 1'b1;
            gap_q   <= '0;
            if (GAP_CYCLES == 0) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_GAP;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
`ifdef PARITY_EN
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              data_q <= par_q;
            end else begin
              data_q <= head_bit_d;
              sh_q   <= sh_d;
            end
`else
            data_q <= head_bit_d;
            sh_q   <= sh_d;
`endif
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_q + 4'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          write_q <= 1'b0;
          data_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dequeue_out = dequeue_q;
  assign data_out    = data_q;
  assign write_out   = write_q;
  assign busy_out    = busy_q;
  assign done_out    = done_q;

endmodule

// File: tb/tb_serializador.sv
// Randomized and directed bench for serializador against a timeline reference model.
// Expected outputs are scheduled per cycle from the byte start rule, not from FSM states.
`timescale 1us/1ns
module tb_serializador;

  localparam int DW  = 8;
  localparam int GAP = 1;
  localparam int MSB = 1;
`ifdef PARITY_EN
  localparam int NB = DW + 1;
`else
  localparam int NB = DW;
`endif
  localparam int PERIOD = 3 + NB + GAP;
  localparam int MAXC   = 2048;

  logic          clk_10KHz = 1'b0;
  logic          reset;
  logic [7:0]    len_in;
  logic [DW-1:0] q_data_in;
  logic          enable_in;
  logic          ready_in;
  logic          dequeue_out;
  logic          data_out;
  logic          write_out;
  logic          busy_out;
  logic          done_out;

  serializador #(.DATA_W(DW), .GAP_CYCLES(GAP), .MSB_FIRST(MSB)) dut (
    .clk_10KHz  (clk_10KHz),
    .reset      (reset),
    .len_in     (len_in),
    .q_data_in  (q_data_in),
    .enable_in  (enable_in),
    .ready_in   (ready_in),
    .dequeue_out(dequeue_out),
    .data_out   (data_out),
    .write_out  (write_out),
    .busy_out   (busy_out),
    .done_out   (done_out)
  );

  always #50 clk_10KHz = ~clk_10KHz;

  bit            e_deq [MAXC];
  bit            e_wr  [MAXC];
  bit            e_dat [MAXC];
  bit            e_busy[MAXC];
  bit            e_done[MAXC];
  bit            q_set [MAXC];
  logic [DW-1:0] q_val [MAXC];

  int            cyc = 0;
  int            next_idle = 0;
  int            n_chk = 0;
  int            n_pass = 0;
  logic [DW-1:0] src[$];
  int            deq_seen[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
  endtask

  // A byte accepted at cycle c occupies a fixed window relative to c.
  task automatic schedule(input int c);
    logic [DW-1:0] b;
    b = (src.size() > 0) ? src.pop_front() : DW'($urandom);
    q_set[c+2] = 1'b1;
    q_val[c+2] = b;
    e_deq[c+1] = 1'b1;
    for (int i = 0; i < NB; i++) begin
      e_wr[c+3+i] = 1'b1;
      if (i < DW) e_dat[c+3+i] = (MSB != 0) ? b[DW-1-i] : b[i];
      else        e_dat[c+3+i] = ^b;
    end
    for (int i = c + 1; i <= c + 2 + NB + GAP; i++) e_busy[i] = 1'b1;
    e_done[c+3+NB] = 1'b1;
    next_idle = c + PERIOD;
  endtask

  task automatic tick(input logic en, input logic rdy, input logic [7:0] len, input logic rst);
    @(posedge clk_10KHz);
    #1;
    cyc++;
    chk("dequeue_out", 32'(dequeue_out), 32'(e_deq[cyc]));
    chk("write_out",   32'(write_out),   32'(e_wr[cyc]));
    chk("data_out",    32'(data_out),    32'(e_dat[cyc]));
    chk("busy_out",    32'(busy_out),    32'(e_busy[cyc]));
    chk("done_out",    32'(done_out),    32'(e_done[cyc]));
    if (dequeue_out === 1'b1) deq_seen.push_back(cyc);
    if (reset && !rst) next_idle = cyc;
    reset     = rst;
    enable_in = en;
    ready_in  = rdy;
    len_in    = len;
    q_data_in = q_set[cyc] ? q_val[cyc] : DW'($urandom);
    if (!rst && cyc >= next_idle && en && rdy && len != 8'd0) schedule(cyc);
  endtask

  task automatic reset_mid_cycle();
    #5;
    reset = 1'b1;
    #1;
    chk("rst_dequeue", 32'(dequeue_out), 32'd0);
    chk("rst_write",   32'(write_out),   32'd0);
    chk("rst_data",    32'(data_out),    32'd0);
    chk("rst_busy",    32'(busy_out),    32'd0);
    chk("rst_done",    32'(done_out),    32'd0);
    for (int i = cyc; i < MAXC; i++) begin
      e_deq[i] = 1'b0; e_wr[i] = 1'b0; e_dat[i] = 1'b0;
      e_busy[i] = 1'b0; e_done[i] = 1'b0; q_set[i] = 1'b0;
    end
  endtask

  initial begin
    reset     = 1'b1;
    len_in    = 8'd0;
    q_data_in = '0;
    enable_in = 1'b0;
    ready_in  = 1'b0;
    #1;
    chk("init_dequeue", 32'(dequeue_out), 32'd0);
    chk("init_write",   32'(write_out),   32'd0);
    chk("init_busy",    32'(busy_out),    32'd0);
    chk("init_done",    32'(done_out),    32'd0);
    tick(1'b0, 1'b0, 8'd0, 1'b1);
    tick(1'b0, 1'b0, 8'd0, 1'b1);

    // Single 0xA5 byte, start coincides with reset release.
    src.push_back(8'hA5);
    tick(1'b1, 1'b1, 8'd1, 1'b0);
    repeat (15) tick(1'b1, 1'b1, 8'd0, 1'b0);

    // Empty queue must never be popped.
    repeat (30) tick(1'b1, 1'b1, 8'd0, 1'b0);

    // Three queued bytes back to back.
    src.push_back(8'h01);
    src.push_back(8'h80);
    src.push_back(8'hFF);
    deq_seen.delete();
    repeat (45) tick(1'b1, 1'b1, 8'(src.size()), 1'b0);
    chk("b2b_pops", 32'(deq_seen.size()), 32'd3);
    if (deq_seen.size() == 3) begin
      chk("b2b_period_1", 32'(deq_seen[1] - deq_seen[0]), 32'(PERIOD));
      chk("b2b_period_2", 32'(deq_seen[2] - deq_seen[1]), 32'(PERIOD));
    end

    src.push_back(8'h07);
    tick(1'b1, 1'b1, 8'd1, 1'b0);
    repeat (16) tick(1'b1, 1'b1, 8'd0, 1'b0);

    // enable_in drops in cycle 5 of a byte with the queue still non-empty.
    src.push_back(8'h3C);
    tick(1'b1, 1'b1, 8'd5, 1'b0);
    repeat (4) tick(1'b1, 1'b1, 8'd5, 1'b0);
    deq_seen.delete();
    repeat (20) tick(1'b0, 1'b1, 8'd5, 1'b0);
    chk("en_drop_no_pop", 32'(deq_seen.size()), 32'd0);

    // Reset in cycle 6 of a byte, then restart with a fresh byte.
    src.push_back(8'h5A);
    tick(1'b1, 1'b1, 8'd1, 1'b0);
    repeat (6) tick(1'b1, 1'b1, 8'd1, 1'b0);
    reset_mid_cycle();
    src.delete();
    repeat (3) tick(1'b1, 1'b1, 8'd1, 1'b1);
    src.push_back(8'hC3);
    tick(1'b1, 1'b1, 8'd1, 1'b0);
    repeat (15) tick(1'b1, 1'b1, 8'd0, 1'b0);

    // Random traffic, including large occupancy values.
    for (int k = 0; k < 700; k++) begin
      logic       en;
      logic       rdy;
      logic [7:0] len;
      int         r;
      en  = ($urandom_range(0, 9) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      r   = $urandom_range(0, 3);
      case (r)
        0:       len = 8'd0;
        1:       len = 8'd1;
        2:       len = 8'($urandom_range(8, 255));
        default: len = 8'($urandom_range(2, 7));
      endcase
      tick(en, rdy, len, 1'b0);
    end
    repeat (20) tick(1'b0, 1'b0, 8'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serializador.md
SERIALIZADOR -- requirements
Module: serializador

Interface
REQ-001 Parameter DATA_W, 8, byte width shifted per transfer.
REQ-002 Parameter GAP_CYCLES, 1, idle cycles (range 0-15) after each byte with write_out low.
REQ-003 Parameter MSB_FIRST, 1, bit order (1 = bit DATA_W-1 first, 0 = bit 0 first).
REQ-004 clk_10KHz  in  1  clock; all state updates on its rising edge.
REQ-005 reset  in  1  reset, asynchronous, active-high.
REQ-006 len_in  in  8  current queue occupancy.
REQ-007 q_data_in  in  DATA_W  queue head data, valid one cycle after a dequeue_out pulse.
REQ-008 enable_in  in  1  transmission permitted.
REQ-009 ready_in  in  1  downstream receiver able to accept a new byte.
REQ-010 dequeue_out  out  1  one-cycle queue pop request.
REQ-011 data_out  out  1  serial data bit.
REQ-012 write_out  out  1  serial bit-valid strobe.
REQ-013 busy_out  out  1  high in every state except IDLE.
REQ-014 done_out  out  1  one-cycle pulse after the last bit of a byte.

Function
REQ-015 FSM states SHALL be IDLE, REQ, LOAD, SHIFT and GAP, and all outputs SHALL be registered.
REQ-016 In IDLE, when enable_in=1, ready_in=1 and len_in!=0, the FSM SHALL go to REQ; otherwise it SHALL stay in IDLE.
REQ-017 In REQ, dequeue_out SHALL be 1 for exactly that one cycle; the next state SHALL be LOAD.
REQ-018 The edge that leaves LOAD SHALL capture q_data_in into the shift register, clear the bit counter and enter SHIFT.
REQ-019 In SHIFT, write_out SHALL be 1 for exactly DATA_W cycles, with data_out carrying one bit per cycle in MSB_FIRST order.
REQ-020 With the FSM in IDLE at cycle 0 and the start condition true, timing SHALL be: dequeue_out in cycle 1, first bit in cycle 3, last bit in cycle 2+DATA_W, done_out in cycle 3+DATA_W.
REQ-021 After SHIFT the FSM SHALL enter GAP for GAP_CYCLES cycles; if GAP_CYCLES=0 it SHALL go directly to IDLE.
REQ-022 data_out SHALL be 0 in every cycle where write_out=0.
REQ-023 enable_in and ready_in SHALL be sampled only in IDLE; deasserting either mid-byte SHALL NOT abort the byte in flight.
REQ-024 With len_in=0 the block SHALL never assert dequeue_out; len_in values of 8 or more SHALL be treated as non-empty.
REQ-025 The bit counter SHALL be $clog2(DATA_W+1) bits wide and SHALL NOT wrap within a byte.
REQ-026 The back-to-back byte period SHALL be 3+DATA_W+GAP_CYCLES cycles (12 for the default parameters).

Reset
REQ-027 On reset=1, the FSM SHALL enter IDLE and dequeue_out, data_out, write_out, busy_out and done_out SHALL be 0 immediately.
REQ-028 Reset mid-byte SHALL discard the remaining bits; the dequeued byte is lost and is not re-requested.
REQ-029 After reset is released, the first start-condition check SHALL occur on the first rising edge.

Configuration
REQ-030 With PARITY_EN defined, SHIFT SHALL last DATA_W+1 cycles, the extra final bit being even parity (XOR of all data bits), and all later timing SHALL shift by +1 cycle.
REQ-031 Without PARITY_EN, no parity logic SHALL exist and the timing SHALL be exactly as in REQ-020.

Structure
REQ-032 Package serializador_pkg SHALL hold the state enum typedef and the DATA_W and GAP_CYCLES default constants.
REQ-033 The block SHALL be a single module with no sub-modules; the parity reduction SHALL be inline.

Verification
REQ-034 len_in=1, q_data_in=8'hA5, enable_in=ready_in=1 -> dequeue_out in cycle 1; data_out 1,0,1,0,0,1,0,1 in cycles 3-10; done_out in cycle 11.
REQ-035 len_in=0 for 30 cycles -> dequeue_out, write_out and busy_out stay 0.
REQ-036 Queue holding 8'h01, 8'h80, 8'hFF, default parameters -> three dequeue_out pulses exactly 12 cycles apart and correct serial bits for each byte.
REQ-037 enable_in dropped in cycle 5 of a byte -> that byte completes with 8 bits, then no further dequeue_out.
REQ-038 reset asserted in cycle 6 -> all outputs 0 at once; after release with len_in=1 the sequence restarts at cycle 0.
REQ-039 PARITY_EN defined, q_data_in=8'h07 -> 9 write_out cycles, last bit 1, done_out in cycle 12.
